// File: rtl/histogram_frame_ctrl.sv
// histogram_frame_ctrl: sequences one histogram bank through accumulate,
// readout and clear for each frame.
// The optional trailer word is enabled by defining CHECKSUM_TRAILER_EN. When it
// is defined, a wrapping DATA_W-bit sum of all bin words follows the last bin
// and carries out_last.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for frame_start, histogram in write mode
// S_ACCUM   | frame in progress, pixel strobes gated through to histogram
// S_RD_WAIT | hist_bin driven, waiting out the histogram read latency
// S_SEND    | word held on out_data/out_valid until the consumer accepts it
// S_CLEAR   | one-cycle clear pulse to histogram, then back to idle
module histogram_frame_ctrl #(
  parameter int BINS   = 1024,
  parameter int BIN_AW = 10,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pixel_valid,
  output logic              hist_pixel_valid,
  output logic              hist_rw,
  output logic [BIN_AW-1:0] hist_bin,
  input  logic [DATA_W-1:0] hist_data,
  output logic              hist_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_RD_WAIT,
    S_SEND,
    S_CLEAR
  } state_t;

  localparam logic [BIN_AW-1:0] BIN_LAST  = BIN_AW'(BINS - 1);
  // The bin counter sits at 0 throughout ACCUM, so the first bin address has
  // already been stable for one cycle when RD_WAIT is entered; later bins pay
  // the full latency after the address changes on the handshake.
  localparam logic [3:0]        LAT_FIRST = 4'(RD_LAT - 1);
  localparam logic [3:0]        LAT_FULL  = 4'(RD_LAT);

  state_t              state_q, state_d;
  logic [BIN_AW-1:0]   bin_q, bin_d;
  logic [3:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          drop_q, drop_d;
  logic                hs;
`ifdef CHECKSUM_TRAILER_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                trl_q, trl_d;
`endif

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      drop_q  <= '0;
`ifdef CHECKSUM_TRAILER_EN
      sum_q   <= '0;
      trl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
`ifdef CHECKSUM_TRAILER_EN
      sum_q   <= sum_d;
      trl_q   <= trl_d;
`endif
    end
  end

  // Next-state, bin walk, read-latency down-counter and drop counting
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lat_d   = lat_q;
    data_d  = data_q;
    drop_d  = drop_q;
`ifdef CHECKSUM_TRAILER_EN
    sum_d   = sum_q;
    trl_d   = trl_q;
`endif
    hs = (state_q == S_SEND) && out_ready;

    if (frame_start && (state_q == S_RD_WAIT || state_q == S_SEND ||
                        state_q == S_CLEAR) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (frame_end) begin
          state_d = S_RD_WAIT;
          bin_d   = '0;
          lat_d   = LAT_FIRST;
`ifdef CHECKSUM_TRAILER_EN
          sum_d   = '0;
          trl_d   = 1'b0;
`endif
        end
      end
      S_RD_WAIT: begin
        if (lat_q == 4'd0) begin
          data_d  = hist_data;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_SEND: begin
        if (hs) begin
`ifdef CHECKSUM_TRAILER_EN
          if (trl_q) begin
            state_d = S_CLEAR;
            bin_d   = '0;
            trl_d   = 1'b0;
          end else if (bin_q == BIN_LAST) begin
            // Trailer goes out straight from SEND; hist_bin stays put.
            sum_d  = sum_q + data_q;
            data_d = sum_q + data_q;
            trl_d  = 1'b1;
          end else begin
            sum_d   = sum_q + data_q;
            bin_d   = bin_q + 1'b1;
            lat_d   = LAT_FULL;
            state_d = S_RD_WAIT;
          end
`else
          if (bin_q == BIN_LAST) begin
            state_d = S_CLEAR;
            bin_d   = '0;
          end else begin
            bin_d   = bin_q + 1'b1;
            lat_d   = LAT_FULL;
            state_d = S_RD_WAIT;
          end
`endif
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hist_pixel_valid = pixel_valid && (state_q == S_ACCUM);
  assign hist_rw          = (state_q == S_IDLE) || (state_q == S_ACCUM) ||
                            (state_q == S_CLEAR);
  assign hist_bin         = bin_q;
  assign hist_clr         = (state_q == S_CLEAR);
  assign out_data         = data_q;
  assign out_valid        = (state_q == S_SEND);
`ifdef CHECKSUM_TRAILER_EN
  assign out_last         = (state_q == S_SEND) && trl_q;
`else
  assign out_last         = (state_q == S_SEND) && (bin_q == BIN_LAST);
`endif
  assign busy             = (state_q != S_IDLE);
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_histogram_frame_ctrl.sv
// Testbench for histogram_frame_ctrl: behavioural histogram bank plus a
// scoreboard of expected bin words built from the pixels the bench drives.
module tb_histogram_frame_ctrl;
  localparam int BINS   = 1024;
  localparam int BIN_AW = 10;
  localparam int DATA_W = 24;
  localparam int RD_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              frame_end = 1'b0;
  logic              pixel_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic              hist_pixel_valid, hist_rw, hist_clr;
  logic              out_valid, out_last, busy;
  logic [BIN_AW-1:0] hist_bin;
  logic [DATA_W-1:0] hist_data, out_data;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  histogram_frame_ctrl #(
    .BINS(BINS), .BIN_AW(BIN_AW), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .hist_pixel_valid(hist_pixel_valid),
    .hist_rw(hist_rw), .hist_bin(hist_bin), .hist_data(hist_data),
    .hist_clr(hist_clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural histogram bank: write on gated strobe, RD_LAT-cycle read
  logic [DATA_W-1:0] mem [BINS];
  logic [BIN_AW-1:0] addr_pipe [RD_LAT];
  logic [BIN_AW-1:0] pix_bin = '0;
  always @(posedge clk) begin
    addr_pipe[0] <= hist_bin;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    if (rst || hist_clr) begin
      for (int i = 0; i < BINS; i++) mem[i] <= '0;
    end else if (hist_pixel_valid && hist_rw) begin
      mem[pix_bin] <= mem[pix_bin] + 1'b1;
    end
  end
  assign hist_data = mem[addr_pipe[RD_LAT-1]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [DATA_W-1:0] exp_data_q [$];
  bit                exp_last_q [$];
  int                exp_cnt [BINS];
  bit                in_frame = 1'b0;
  bit                rnd_ready = 1'b0;
  int                clr_cnt = 0;
  int                clr_cyc = 0;
  bit                prev_stall = 1'b0;
  bit                prev_last_hs = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [BIN_AW-1:0] prev_bin;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (hist_clr) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (prev_last_hs) check("clr_after_last", 32'(hist_clr), 32'd1);
      if (prev_stall) begin
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_bin", 32'(hist_bin), 32'(prev_bin));
        check("stall_valid", 32'(out_valid), 32'd1);
      end
      if (pixel_valid && !in_frame) check("pixel_gate", 32'(hist_pixel_valid), 32'd0);
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("extra_word", 32'(out_valid && out_ready), 32'd0);
        end else begin
          check("word_data", 32'(out_data), 32'(exp_data_q.pop_front()));
          check("word_last", 32'(out_last), 32'(exp_last_q.pop_front()));
        end
        prev_last_hs = out_last;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bin   = hist_bin;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_expected();
    logic [DATA_W-1:0] sum;
    sum = '0;
    for (int b = 0; b < BINS; b++) begin
      exp_data_q.push_back(DATA_W'(exp_cnt[b]));
      sum = sum + DATA_W'(exp_cnt[b]);
`ifdef CHECKSUM_TRAILER_EN
      exp_last_q.push_back(1'b0);
`else
      exp_last_q.push_back(b == BINS - 1);
`endif
      exp_cnt[b] = 0;
    end
`ifdef CHECKSUM_TRAILER_EN
    exp_data_q.push_back(sum);
    exp_last_q.push_back(1'b1);
`endif
  endtask

  // mode 0: every pixel in bin 5; mode 1: pixels spread over bins 0..9
  task automatic run_frame(input int npix, input int mode, input bit start_mid,
                           output int fe_cyc);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    in_frame = 1'b1;
    check("busy_accum", 32'(busy), 32'd1);
    check("rw_accum", 32'(hist_rw), 32'd1);
    for (int i = 0; i < npix; i++) begin
      pix_bin = (mode == 0) ? BIN_AW'(5) : BIN_AW'(i % 10);
      pixel_valid = 1'b1;
      frame_start = start_mid && (i == npix / 2);
      exp_cnt[pix_bin]++;
      tick();
      pixel_valid = 1'b0;
      frame_start = 1'b0;
      if (i % 3 == 0) tick();
    end
    frame_end = 1'b1;
    fe_cyc = cyc;
    tick();
    frame_end = 1'b0;
    in_frame = 1'b0;
    push_expected();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int fe_cyc;
    int n;
    int c0;
    for (int b = 0; b < BINS; b++) exp_cnt[b] = 0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rw", 32'(hist_rw), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr", 32'(hist_clr), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_bin", 32'(hist_bin), 32'd0);
    rst = 1'b0;
    tick();

    // Frame A: 16 pixels in bin 5, ready high, frame_start mid-frame ignored
    run_frame(16, 0, 1'b1, fe_cyc);
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("first_latency", 32'(n), 32'(RD_LAT + 1));
    wait_idle(20000);
`ifdef CHECKSUM_TRAILER_EN
    check("frame_cycles", 32'(clr_cyc - fe_cyc), 32'(BINS * (RD_LAT + 2) + 1));
`else
    check("frame_cycles", 32'(clr_cyc - fe_cyc), 32'(BINS * (RD_LAT + 2)));
`endif
    check("clr_count_a", 32'(clr_cnt), 32'd1);
    check("queue_drained_a", 32'(exp_data_q.size()), 32'd0);
    check("drop_accum_ignored", 32'(drop_cnt), 32'd0);
    check("rw_after_a", 32'(hist_rw), 32'd1);

    // Frame B: pixel_valid held in IDLE and readout, random backpressure
    pix_bin = BIN_AW'(3);
    pixel_valid = 1'b1;
    repeat (5) tick();
    rnd_ready = 1'b1;
    run_frame(300, 1, 1'b0, fe_cyc);
    pix_bin = BIN_AW'(7);
    pixel_valid = 1'b1;
    wait_idle(40000);
    pixel_valid = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    check("clr_count_b", 32'(clr_cnt), 32'd2);
    check("queue_drained_b", 32'(exp_data_q.size()), 32'd0);

    // Frame C: three frame_start pulses during readout are dropped
    run_frame(16, 0, 1'b0, fe_cyc);
    repeat (3) begin
      repeat (400) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    wait_idle(20000);
    check("drop_cnt_3", 32'(drop_cnt), 32'd3);
    check("clr_count_c", 32'(clr_cnt), 32'd3);
    check("queue_drained_c", 32'(exp_data_q.size()), 32'd0);

    // Frame D: normal start after drops, reset at bin 500 of readout
    run_frame(30, 1, 1'b0, fe_cyc);
    n = 0;
    while (!(hist_bin == BIN_AW'(500) && out_valid) && n < 10000) begin
      tick();
      n++;
    end
    check("reach_bin500", 32'(hist_bin), 32'd500);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_bin", 32'(hist_bin), 32'd0);
    check("mid_rst_rw", 32'(hist_rw), 32'd1);
    check("mid_rst_clr", 32'(hist_clr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    exp_data_q.delete();
    exp_last_q.delete();
    c0 = clr_cnt;
    repeat (10) tick();
    check("no_clr_after_rst", 32'(clr_cnt), 32'(c0));

    // frame_end alone in IDLE is ignored; with frame_start, start wins
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("fe_idle_ignored", 32'(busy), 32'd0);
    frame_start = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_end = 1'b0;
    check("start_end_busy", 32'(busy), 32'd1);
    check("start_end_rw", 32'(hist_rw), 32'd1);
    tick();
    check("start_end_stay_accum", 32'(hist_rw), 32'd1);
    check("start_end_no_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
